// File: rtl/mul_scheduler.sv
// Issue scheduler for the shared multi-cycle multiplier: one buffered request
// per port, round-robin grant, start/finish sequencing and a tagged writeback.
module mul_scheduler #(
  parameter int NUM_REQ   = 2,
  parameter int ID_W      = 2,
  parameter int PRF_WIDTH = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*10-1:0]          req_op,
  input  logic [NUM_REQ*64-1:0]          req_op1,
  input  logic [NUM_REQ*64-1:0]          req_op2,
  input  logic [NUM_REQ*PRF_WIDTH-1:0]   req_prd,
  output logic                           mul_start,
  output logic [9:0]                     mul_op_f3,
  output logic [63:0]                    mul_op1,
  output logic [63:0]                    mul_op2,
  input  logic [63:0]                    mul_product,
  input  logic                           mul_finish,
  input  logic                           mul_busy,
  output logic                           wb_valid,
  input  logic                           wb_ready,
  output logic [63:0]                    wb_data,
  output logic [PRF_WIDTH-1:0]           wb_prd,
  output logic [ID_W-1:0]                wb_src,
  output logic [2:0]                     dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and an offered writeback holds
  // its data stable until it is taken (or killed by flush/reset).

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [NUM_REQ-1:0]   slot_valid;
  logic [9:0]           slot_op  [NUM_REQ];
  logic [63:0]          slot_op1 [NUM_REQ];
  logic [63:0]          slot_op2 [NUM_REQ];
  logic [PRF_WIDTH-1:0] slot_prd [NUM_REQ];

  logic [ID_W-1:0]      last;
  logic [ID_W-1:0]      win;
  logic [ID_W:0]        pos;
  logic [NUM_REQ-1:0]   rot;
  logic                 win_found;
  logic                 grant;

  logic [9:0]           sel_op;
  logic [63:0]          sel_op1;
  logic [63:0]          sel_op2;
  logic [PRF_WIDTH-1:0] sel_prd;
  logic [PRF_WIDTH-1:0] prd_q;
  logic [ID_W-1:0]      src_q;

  // Ready is built from registered slot state, so a freed slot refills next cycle.
  assign req_ready = ~slot_valid & {NUM_REQ{~flush}};
  assign grant     = (state == IDLE) && win_found && !mul_busy && !flush;
  assign mul_start = (state == ISSUE) && !flush;
  assign wb_valid  = (state == RESP) && !flush;
  assign wb_prd    = prd_q;
  assign wb_src    = src_q;
  assign dbg_state = state;

  // Round-robin pick: rotate the valid mask so the port after `last` is bit 0.
  always_comb begin
    rot       = NUM_REQ'({slot_valid, slot_valid} >> ({1'b0, last} + 1'b1));
    pos       = '0;
    win_found = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!win_found && rot[j]) begin
        win_found = 1'b1;
        pos       = {1'b0, last} + 1'b1 + (ID_W+1)'(j);
      end
    end
    if (pos >= (ID_W+1)'(NUM_REQ)) pos = pos - (ID_W+1)'(NUM_REQ);
    win = pos[ID_W-1:0];
  end

  // Operand mux for the winning slot.
  always_comb begin
    sel_op  = '0;
    sel_op1 = '0;
    sel_op2 = '0;
    sel_prd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == ID_W'(i)) begin
        sel_op  = slot_op[i];
        sel_op1 = slot_op1[i];
        sel_op2 = slot_op2[i];
        sel_prd = slot_prd[i];
      end
    end
  end

  // Request slots: load on handshake, free on grant, wiped by flush or reset.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      slot_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant && (win == ID_W'(i))) slot_valid[i] <= 1'b0;
        if (req_valid[i] && req_ready[i]) begin
          slot_valid[i] <= 1'b1;
          slot_op[i]    <= req_op[i*10 +: 10];
          slot_op1[i]   <= req_op1[i*64 +: 64];
          slot_op2[i]   <= req_op2[i*64 +: 64];
          slot_prd[i]   <= req_prd[i*PRF_WIDTH +: PRF_WIDTH];
        end
      end
    end
  end

  // Issue operands, tag, pointer and captured product; only a grant moves them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mul_op_f3 <= '0;
      mul_op1   <= '0;
      mul_op2   <= '0;
      prd_q     <= '0;
      src_q     <= '0;
      wb_data   <= '0;
      last      <= ID_W'(NUM_REQ-1);
    end else begin
      if (grant) begin
        mul_op_f3 <= sel_op;
        mul_op1   <= sel_op1;
        mul_op2   <= sel_op2;
        prd_q     <= sel_prd;
        src_q     <= win;
        last      <= win;
      end
      if ((state == WAIT) && mul_finish && !flush) wb_data <= mul_product;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state; flush overrides every normal transition.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = ISSUE;
      ISSUE:   state_nxt = flush ? IDLE : WAIT;
      WAIT: begin
        if (flush)           state_nxt = mul_finish ? IDLE : DRAIN;
        else if (mul_finish) state_nxt = RESP;
      end
      RESP:    if (flush || wb_ready) state_nxt = IDLE;
      DRAIN:   if (mul_finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mul_scheduler.sv
// Bench for mul_scheduler: queue-based port driver, behavioural multiplier,
// per-port expected queues and directed/random scenario tasks.
module tb_mul_scheduler;
  localparam int NUM_REQ = 3;
  localparam int ID_W    = 2;
  localparam int PW      = 6;
  localparam logic [9:0] OP_MUL    = 10'b0110011_000;
  localparam logic [9:0] OP_MULH   = 10'b0110011_001;
  localparam logic [9:0] OP_MULHSU = 10'b0110011_010;
  localparam logic [9:0] OP_MULHU  = 10'b0110011_011;
  localparam logic [9:0] OP_MULW   = 10'b0111011_000;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DRAIN  = 3'd4;
  localparam logic [63:0] NEG5     = 64'hFFFF_FFFF_FFFF_FFFB;

  typedef struct packed {
    logic [9:0]    op;
    logic [63:0]   a;
    logic [63:0]   b;
    logic [PW-1:0] prd;
  } req_t;

  logic clk = 1'b0;
  logic rst, flush, wb_ready;
  logic [NUM_REQ-1:0]    req_valid, req_ready;
  logic [NUM_REQ*10-1:0] req_op;
  logic [NUM_REQ*64-1:0] req_op1, req_op2;
  logic [NUM_REQ*PW-1:0] req_prd;
  logic        mul_start, mul_finish, mul_busy, wb_valid;
  logic [9:0]  mul_op_f3;
  logic [63:0] mul_op1, mul_op2, mul_product, wb_data;
  logic [PW-1:0]   wb_prd;
  logic [ID_W-1:0] wb_src;
  logic [2:0]      dbg_state;

  req_t            pend_q [NUM_REQ][$];
  logic [PW+63:0]  exp_q  [NUM_REQ][$];
  logic [ID_W-1:0] rsp_src_log[$];
  logic [63:0]     rsp_data_log[$];
  logic [PW-1:0]   rsp_prd_log[$];

  int total, bad, n_starts, n_rsp, m_lat, m_cnt, cyc, acc_cyc, rsp_cyc;
  logic [63:0] m_res;

  always #5 clk = ~clk;

  mul_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .PRF_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_op1(req_op1), .req_op2(req_op2), .req_prd(req_prd),
    .mul_start(mul_start), .mul_op_f3(mul_op_f3), .mul_op1(mul_op1), .mul_op2(mul_op2),
    .mul_product(mul_product), .mul_finish(mul_finish), .mul_busy(mul_busy),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_prd(wb_prd), .wb_src(wb_src), .dbg_state(dbg_state)
  );

  // RV64 M-extension result from 128-bit products of the extended operands.
  function automatic logic [63:0] ref_mul(input logic [9:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] sa, sb, ua, ub, p;
    ua = {64'd0, a};
    ub = {64'd0, b};
    sa = {{64{a[63]}}, a};
    sb = {{64{b[63]}}, b};
    if (op == OP_MULW) begin
      p = ua * ub;
      return {{32{p[31]}}, p[31:0]};
    end
    case (op[2:0])
      3'd1:    p = sa * sb;
      3'd2:    p = sa * ub;
      3'd3:    p = ua * ub;
      default: begin p = ua * ub; return p[63:0]; end
    endcase
    return p[127:64];
  endfunction

  function automatic logic [9:0] pick_op(input int k);
    case (k)
      0: return OP_MUL;
      1: return OP_MULH;
      2: return OP_MULHSU;
      3: return OP_MULHU;
      default: return OP_MULW;
    endcase
  endfunction

  // Port driver, multiplier model and writeback scoreboard.
  initial begin : bg
    logic [NUM_REQ-1:0] acc;
    logic [PW+63:0] e;
    req_t r;
    acc = '0; m_cnt = 0; cyc = 0;
    req_valid = '0; req_op = '0; req_op1 = '0; req_op2 = '0; req_prd = '0;
    mul_finish = 1'b0; mul_busy = 1'b0; mul_product = '0; m_res = '0;
    forever begin
      @(negedge clk);
      cyc++;
      mul_finish = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          mul_finish = 1'b1; mul_product = m_res; mul_busy = 1'b0;
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc[i]) begin
          r = pend_q[i].pop_front();
          exp_q[i].push_back({r.prd, ref_mul(r.op, r.a, r.b)});
        end
        if (pend_q[i].size() > 0) begin
          r = pend_q[i][0];
          req_valid[i] = 1'b1;
          req_op[i*10 +: 10]   = r.op;
          req_op1[i*64 +: 64]  = r.a;
          req_op2[i*64 +: 64]  = r.b;
          req_prd[i*PW +: PW]  = r.prd;
        end else begin
          req_valid[i] = 1'b0;
        end
      end
      #1;
      if (!rst) begin
        acc = '0; m_cnt = 0; mul_busy = 1'b0; mul_finish = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) exp_q[i].delete();
      end else begin
        acc = req_valid & req_ready;
        if (acc != '0) acc_cyc = cyc;
        if (flush) for (int i = 0; i < NUM_REQ; i++) exp_q[i].delete();
        if (wb_valid && wb_ready) begin
          total++;
          if (int'(wb_src) >= NUM_REQ || exp_q[wb_src].size() == 0) begin
            bad++;
            $display("FAIL wb_unexpected src=%0d data=%h prd=%0d", wb_src, wb_data, wb_prd);
          end else begin
            e = exp_q[wb_src].pop_front();
            if ({wb_prd, wb_data} !== e) begin
              bad++;
              $display("FAIL wb_result src=%0d got prd=%0d data=%h want prd=%0d data=%h",
                       wb_src, wb_prd, wb_data, e[PW+63:64], e[63:0]);
            end
          end
          n_rsp++; rsp_cyc = cyc;
          rsp_src_log.push_back(wb_src); rsp_data_log.push_back(wb_data); rsp_prd_log.push_back(wb_prd);
        end
        if (mul_start) begin
          total++;
          if (mul_busy || m_cnt > 0) begin
            bad++;
            $display("FAIL start_while_busy got start=1 want start=0 (cnt=%0d)", m_cnt);
          end
          n_starts++;
          m_cnt = m_lat; mul_busy = 1'b1;
          m_res = ref_mul(mul_op_f3, mul_op1, mul_op2);
        end
      end
    end
  end

  task automatic wait_rsp(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk); #2;
      if (n_rsp >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_start(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk); #2;
      if (n_starts >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [214:0] obs, want;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    obs  = {req_ready, mul_start, mul_op_f3, mul_op1, mul_op2, wb_valid, wb_data, wb_prd, wb_src};
    want = {3'b111, 212'd0};
    total++;
    if (obs !== want) begin bad++; $display("FAIL reset_outputs got %h want %h", obs, want); end
    total++;
    if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL reset_state got %0d want %0d", dbg_state, ST_IDLE); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_single();
    int r0, s0; bit ok;
    m_lat = $urandom_range(1, 6);
    wb_ready = 1'b1; r0 = n_rsp; s0 = n_starts;
    @(negedge clk); #2;
    pend_q[0].push_back('{OP_MUL, 64'd5, NEG5, 6'd17});
    wait_rsp(r0 + 1, 60, ok);
    repeat (3) @(negedge clk);
    total++;
    if (!ok) begin bad++; $display("FAIL single_timeout got rsp=%0d want %0d", n_rsp - r0, 1); end
    else begin
      total++;
      if (rsp_data_log[r0] !== 64'hFFFF_FFFF_FFFF_FFE7 || rsp_src_log[r0] !== 2'd0 || rsp_prd_log[r0] !== 6'd17) begin
        bad++; $display("FAIL single_result got data=%h src=%0d prd=%0d want data=ffffffffffffffe7 src=0 prd=17",
                        rsp_data_log[r0], rsp_src_log[r0], rsp_prd_log[r0]);
      end
      if (rsp_cyc - acc_cyc !== 3 + m_lat) begin
        bad++; $display("FAIL single_latency got %0d want %0d", rsp_cyc - acc_cyc, 3 + m_lat);
      end
    end
    total++;
    if (n_starts - s0 !== 1) begin bad++; $display("FAIL single_start_count got %0d want 1", n_starts - s0); end
  endtask

  task automatic test_round_robin();
    int r0; bit ok; logic [63:0] want_d;
    pulse_reset();
    m_lat = $urandom_range(1, 6);
    wb_ready = 1'b1; r0 = n_rsp;
    #2;
    for (int k = 0; k < 2; k++) begin
      pend_q[0].push_back('{OP_MULH, 64'd5, NEG5, PW'(k)});
      pend_q[1].push_back('{OP_MULHU, NEG5, NEG5, PW'(k + 8)});
    end
    wait_rsp(r0 + 4, 200, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rr_timeout got rsp=%0d want 4", n_rsp - r0); end
    else begin
      for (int k = 0; k < 4; k++) begin
        want_d = (k % 2 == 1) ? 64'hFFFF_FFFF_FFFF_FFF6 : 64'hFFFF_FFFF_FFFF_FFFF;
        total++;
        if (rsp_src_log[r0 + k] !== ID_W'(k % 2) || rsp_data_log[r0 + k] !== want_d) begin
          bad++; $display("FAIL rr_grant_%0d got src=%0d data=%h want src=%0d data=%h",
                          k, rsp_src_log[r0 + k], rsp_data_log[r0 + k], k % 2, want_d);
        end
      end
    end
  endtask

  task automatic test_mulw_stall();
    int r0, s0; bit ok;
    m_lat = $urandom_range(1, 6);
    r0 = n_rsp;
    @(negedge clk); wb_ready = 1'b0; #2;
    pend_q[2].push_back('{OP_MULW, 64'd5, 64'hFFFF_0000_FFFF_FFFB, 6'd33});
    ok = 1'b0;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(negedge clk); #2;
      ok = wb_valid;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL stall_timeout got wb_valid=0 want 1"); end
    s0 = n_starts;
    pend_q[0].push_back('{OP_MUL, 64'd2, 64'd3, 6'd4});
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #2;
      total++;
      if (wb_valid !== 1'b1 || wb_data !== 64'hFFFF_FFFF_FFFF_FFE7 || wb_src !== 2'd2) begin
        bad++; $display("FAIL stall_hold_%0d got valid=%b data=%h src=%0d want valid=1 data=ffffffffffffffe7 src=2",
                        c, wb_valid, wb_data, wb_src);
      end
    end
    total++;
    if (n_starts !== s0) begin bad++; $display("FAIL stall_no_start got %0d want %0d", n_starts, s0); end
    @(negedge clk); wb_ready = 1'b1;
    wait_rsp(r0 + 2, 60, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL stall_drain_timeout got rsp=%0d want 2", n_rsp - r0); end
    else if (rsp_src_log[r0 + 1] !== 2'd0 || rsp_data_log[r0 + 1] !== 64'd6) begin
      bad++; $display("FAIL stall_next got src=%0d data=%h want src=0 data=6", rsp_src_log[r0 + 1], rsp_data_log[r0 + 1]);
    end
  endtask

  task automatic test_flush_wait();
    int r0, s0; bit ok;
    m_lat = 6; wb_ready = 1'b1; r0 = n_rsp; s0 = n_starts;
    @(negedge clk); #2;
    pend_q[0].push_back('{OP_MUL, 64'd3, 64'd4, 6'd1});
    wait_start(s0 + 1, 20, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL flushw_start_timeout got starts=%0d want 1", n_starts - s0); end
    @(negedge clk); flush = 1'b1; #2;
    pend_q[1].push_back('{OP_MUL, 64'd7, 64'd9, 6'd9});
    @(negedge clk); flush = 1'b0; #2;
    total++;
    if (dbg_state !== ST_DRAIN || wb_valid !== 1'b0) begin
      bad++; $display("FAIL flushw_drain got state=%0d wb_valid=%b want state=%0d wb_valid=0", dbg_state, wb_valid, ST_DRAIN);
    end
    wait_rsp(r0 + 1, 80, ok);
    repeat (4) @(negedge clk);
    total++;
    if (!ok) begin bad++; $display("FAIL flushw_timeout got rsp=%0d want 1", n_rsp - r0); end
    else if (n_rsp - r0 !== 1 || rsp_src_log[r0] !== 2'd1 || rsp_data_log[r0] !== 64'd63) begin
      bad++; $display("FAIL flushw_result got n=%0d src=%0d data=%h want n=1 src=1 data=3f",
                      n_rsp - r0, rsp_src_log[r0], rsp_data_log[r0]);
    end
    total++;
    if (n_starts - s0 !== 2) begin bad++; $display("FAIL flushw_starts got %0d want 2", n_starts - s0); end
  endtask

  task automatic test_flush_issue();
    int r0, s0;
    r0 = n_rsp; s0 = n_starts; m_lat = 3;
    @(negedge clk); #2;
    pend_q[0].push_back('{OP_MUL, 64'd11, 64'd12, 6'd2});
    pend_q[1].push_back('{OP_MUL, 64'd13, 64'd14, 6'd3});
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); flush = 1'b1; #2;
    total++;
    if (mul_start !== 1'b0) begin bad++; $display("FAIL flushi_start got %b want 0", mul_start); end
    @(negedge clk); flush = 1'b0; #2;
    total++;
    if (req_ready !== 3'b111 || dbg_state !== ST_IDLE) begin
      bad++; $display("FAIL flushi_empty got ready=%b state=%0d want ready=111 state=%0d", req_ready, dbg_state, ST_IDLE);
    end
    repeat (8) @(negedge clk);
    total++;
    if (n_starts !== s0 || n_rsp !== r0) begin
      bad++; $display("FAIL flushi_quiet got starts=%0d rsp=%0d want starts=%0d rsp=%0d", n_starts, n_rsp, s0, r0);
    end
  endtask

  task automatic test_reset_mid();
    int r0, s0; bit ok; logic [214:0] obs, want;
    m_lat = 6; s0 = n_starts;
    @(negedge clk); #2;
    pend_q[0].push_back('{OP_MUL, 64'd1, 64'd2, 6'd7});
    wait_start(s0 + 1, 20, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rstmid_start_timeout got starts=%0d want 1", n_starts - s0); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1; #2;
    obs  = {req_ready, mul_start, mul_op_f3, mul_op1, mul_op2, wb_valid, wb_data, wb_prd, wb_src};
    want = {3'b111, 212'd0};
    total++;
    if (obs !== want) begin bad++; $display("FAIL rstmid_outputs got %h want %h", obs, want); end
    r0 = n_rsp;
    pend_q[1].push_back('{OP_MUL, 64'd7, 64'd6, 6'd5});
    wait_rsp(r0 + 1, 40, ok);
    repeat (3) @(negedge clk);
    total++;
    if (!ok) begin bad++; $display("FAIL rstmid_timeout got rsp=%0d want 1", n_rsp - r0); end
    else if (n_rsp - r0 !== 1 || rsp_data_log[r0] !== 64'd42 || rsp_prd_log[r0] !== 6'd5) begin
      bad++; $display("FAIL rstmid_result got n=%0d data=%0d prd=%0d want n=1 data=42 prd=5",
                      n_rsp - r0, rsp_data_log[r0], rsp_prd_log[r0]);
    end
  endtask

  task automatic test_random();
    int r0, n; bit done;
    n = 40; r0 = n_rsp; m_lat = $urandom_range(1, 5);
    @(negedge clk); #2;
    for (int k = 0; k < n; k++) begin
      pend_q[$urandom_range(0, NUM_REQ - 1)].push_back(
        '{pick_op($urandom_range(0, 4)), {$urandom, $urandom}, {$urandom, $urandom}, PW'($urandom)});
    end
    done = 1'b0;
    for (int c = 0; c < 4000 && !done; c++) begin
      @(negedge clk); wb_ready = ($urandom_range(0, 3) != 0); #2;
      done = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) if (pend_q[i].size() != 0 || exp_q[i].size() != 0) done = 1'b0;
    end
    wb_ready = 1'b1;
    total++;
    if (!done) begin bad++; $display("FAIL random_timeout got rsp=%0d want %0d", n_rsp - r0, n); end
    total++;
    if (n_rsp - r0 !== n) begin bad++; $display("FAIL random_count got %0d want %0d", n_rsp - r0, n); end
  endtask

  initial begin
    total = 0; bad = 0; n_starts = 0; n_rsp = 0; m_lat = 3; acc_cyc = 0; rsp_cyc = 0;
    rst = 1'b0; flush = 1'b0; wb_ready = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_mulw_stall();
    test_flush_wait();
    test_flush_issue();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
